// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the HI/LO path.
// Handles MULT, MULTU, DIV and DIVU on Width-bit operands, one bit per cycle.
// Multiply uses shift-add and divide uses restoring division, both on magnitudes.
// Sign correction is applied in a single FIXUP cycle before the result is written.
module mul_div_unit #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    localparam int unsigned     CntW    = $clog2(Width + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(Width);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state, next_state;

    // Operation context latched on acceptance
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic [Width-1:0] a_mag;
    logic [Width-1:0] b_mag;
    logic [CntW-1:0]  cnt;

    // Working accumulator: {acc_hi, acc_lo} is the product or {remainder, quotient}
    logic [Width-1:0] acc_hi;
    logic [Width-1:0] acc_lo;

    logic             accept;
    logic             in_neg_a;
    logic             in_neg_b;
    logic [Width-1:0] in_a_mag;
    logic [Width-1:0] in_b_mag;

    logic [Width:0]   mul_sum;
    logic [Width-1:0] mul_hi_next;
    logic [Width-1:0] mul_lo_next;

    logic [Width:0]   div_shift;
    logic [Width+1:0] div_diff;
    logic             div_fits;
    logic [Width-1:0] div_hi_next;
    logic [Width-1:0] div_lo_next;
    logic             unused_div_bit;

    logic [2*Width-1:0] prod;
    logic [Width-1:0]   res_hi;
    logic [Width-1:0]   res_lo;

    // New work is accepted from IDLE or DONE only; start during CALC/FIXUP is dropped
    assign accept = start_i && ((state == S_IDLE) || (state == S_DONE));

    // Signed ops (op_i[0] == 0) work on magnitudes; the most negative value's
    // magnitude 2^(Width-1) still fits in Width unsigned bits.
    assign in_neg_a = ~op_i[0] & a_i[Width-1];
    assign in_neg_b = ~op_i[0] & b_i[Width-1];
    assign in_a_mag = in_neg_a ? -a_i : a_i;
    assign in_b_mag = in_neg_b ? -b_i : b_i;

    // One shift-add multiply step: conditionally add multiplicand to the upper half, shift right
    assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : '0);
    assign mul_hi_next = mul_sum[Width:1];
    assign mul_lo_next = {mul_sum[0], acc_lo[Width-1:1]};

    // One restoring divide step: shift in next dividend bit, keep the difference if no borrow
    assign div_shift      = {acc_hi, acc_lo[Width-1]};
    assign div_diff       = {1'b0, div_shift} - {2'b00, b_mag};
    assign div_fits       = ~div_diff[Width+1];
    assign div_hi_next    = div_fits ? div_diff[Width-1:0] : div_shift[Width-1:0];
    assign div_lo_next    = {acc_lo[Width-2:0], div_fits};
    assign unused_div_bit = div_diff[Width];

    assign prod = {acc_hi, acc_lo};

    // Sign correction and divide-by-zero override applied in FIXUP
    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (!is_div) begin
            {res_hi, res_lo} = (neg_a ^ neg_b) ? -prod : prod;
        end else if (b_mag == '0) begin
            // Rebuild the original dividend bit pattern from magnitude and sign
            res_hi = neg_a ? -a_mag : a_mag;
            res_lo = '1;
        end else begin
            res_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
            res_hi = neg_a ? -acc_hi : acc_hi;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) next_state = S_CALC;
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (cnt == CntW'(1)) next_state = S_FIXUP;
            end
            S_FIXUP: begin
                busy_o     = 1'b1;
                next_state = S_DONE;
            end
            S_DONE: begin
                done_o     = 1'b1;
                next_state = start_i ? S_CALC : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: operand latch, per-cycle iteration, and HI/LO write in FIXUP
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else if (accept) begin
            is_div <= op_i[1];
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            a_mag  <= in_a_mag;
            b_mag  <= in_b_mag;
            cnt    <= CntLoad;
            acc_hi <= '0;
            acc_lo <= op_i[1] ? in_a_mag : in_b_mag;
        end else if (state == S_CALC) begin
            cnt <= cnt - CntW'(1);
            if (is_div) begin
                acc_hi <= div_hi_next;
                acc_lo <= div_lo_next;
            end else begin
                acc_hi <= mul_hi_next;
                acc_lo <= mul_lo_next;
            end
        end else if (state == S_FIXUP) begin
            hi_o <= res_hi;
            lo_o <= res_lo;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit (Width = 32): vector table plus
// hand-written sequences for back-to-back issue and asynchronous reset.
module tb_mul_div_unit;

    localparam int unsigned W   = 32;
    localparam int          LAT = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.Width(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .busy_o (busy),
        .done_o (done),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; returns edges from acceptance to done,
    // busy cycle count, and whether hi/lo held their old value meanwhile.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          output int lat, output int busy_cnt, output logic held);
        logic [W-1:0] hi0, lo0;
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        hi0 = hi; lo0 = lo;
        held = 1'b1; lat = 0; busy_cnt = 0;
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            #1;
            start = 1'b0;
            if (done) break;
            if (busy) busy_cnt++;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat, bcnt, n;
        logic        held, seen;
        logic [W-1:0] hi0, lo0;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7]  = '{OP_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
        vecs[8]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
        vecs[12] = '{OP_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800};
        vecs[13] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        chk_i("reset_busy", int'(busy), 0);
        chk_i("reset_done", int'(done), 0);
        chk_w("reset_hi", hi, '0);
        chk_w("reset_lo", lo, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, lat, bcnt, held);
            chk_i($sformatf("v%0d_latency", v), lat, LAT);
            chk_i($sformatf("v%0d_busy_cycles", v), bcnt, LAT);
            chk_i($sformatf("v%0d_hold", v), int'(held), 1);
            chk_w($sformatf("v%0d_hi", v), hi, vecs[v].hi);
            chk_w($sformatf("v%0d_lo", v), lo, vecs[v].lo);
            @(posedge clk);
            #1;
            chk_i($sformatf("v%0d_done_single", v), int'(done), 0);
        end

        // start held high with changing operands during CALC, then held into DONE
        @(negedge clk);
        op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            a = $urandom; b = $urandom; op = 2'($urandom);
            if (done) break;
            @(posedge clk);
            n++;
        end
        chk_i("hold_start_latency", n, LAT);
        chk_w("hold_start_hi", hi, 32'h0);
        chk_w("hold_start_lo", lo, 32'hC);
        op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_i("b2b_busy", int'(busy), 1);
        chk_i("b2b_done_low", int'(done), 0);
        hi0 = hi; lo0 = lo;
        chk_w("b2b_old_hi", hi0, 32'h0);
        chk_w("b2b_old_lo", lo0, 32'hC);
        n = 0; held = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk_i("b2b_latency", n, LAT);
        chk_i("b2b_hold", int'(held), 1);
        chk_w("b2b_hi", hi, 32'h2);
        chk_w("b2b_lo", lo, 32'hE);

        // asynchronous reset mid-CALC
        @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_i("arst_busy", int'(busy), 0);
        chk_i("arst_done", int'(done), 0);
        chk_w("arst_hi", hi, '0);
        chk_w("arst_lo", lo, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk_i("arst_no_done", int'(seen), 0);
        run_op(OP_MULTU, 32'd3, 32'd4, lat, bcnt, held);
        chk_i("arst_after_latency", lat, LAT);
        chk_w("arst_after_hi", hi, 32'h0);
        chk_w("arst_after_lo", lo, 32'hC);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the pipeline's HI/LO path.
- Executes MULT, MULTU, DIV and DIVU on Width-bit operands, one bit per cycle: shift-add for multiply, restoring division for divide.
- Sits beside the execute-stage ALU.
- A start/busy/done handshake lets the hazard unit stall HI/LO readers until the result is ready.

Parameters:
- Width, 32, operand width in bits; hi_o and lo_o are each Width bits; legal range 4..64.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request a new operation; sampled on the rising edge.
- op_i  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- a_i  input  Width  multiplicand or dividend; sampled with start_i.
- b_i  input  Width  multiplier or divisor; sampled with start_i.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle pulse: hi_o and lo_o have just been updated.
- hi_o  output  Width  upper product half, or remainder.
- lo_o  output  Width  lower product half, or quotient.

Behaviour:
- Clocking and reset: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- Reset values, asserted at any time including mid-operation:
  - state = IDLE.
  - busy_o = 0, done_o = 0.
  - hi_o = 0, lo_o = 0.
  - All internal accumulators and counters cleared.
  - After deassertion the unit is in IDLE and any in-flight operation is discarded.
- States:
  - IDLE: busy_o=0, done_o=0.
  - CALC: busy_o=1.
  - FIXUP: busy_o=1.
  - DONE: busy_o=0, done_o=1.
- Transitions:
  - IDLE or DONE, start_i=1 -> CALC. Latch op, a_i, b_i; for signed ops latch magnitudes plus sign flags; load counter = Width.
  - IDLE, start_i=0 -> IDLE.
  - DONE, start_i=0 -> IDLE. This allows back-to-back issue from DONE with no bubble.
  - CALC: one iteration per cycle; the counter decrements; when it reaches 0, go to FIXUP.
  - FIXUP: apply sign correction and write hi_o/lo_o; go to DONE.
- Latency:
  - Accepting edge = E.
  - The edge that writes hi_o/lo_o is E+Width+1.
  - done_o is high for exactly the one cycle after E+Width+1.
  - For Width=32: done_o follows the 33rd edge after acceptance.
- Busy handling: start_i while in CALC or FIXUP is ignored; no queuing, no abort.
- Output stability: hi_o/lo_o change only on the FIXUP->DONE edge. They hold their previous values throughout CALC (HI/LO semantics).
- Multiply:
  - Result is the 2*Width-bit product; hi_o = upper half, lo_o = lower half.
  - MULTU is unsigned.
  - MULT: the magnitude product is negated (two's complement over 2*Width bits) iff sign(a) XOR sign(b).
- Divide: quotient truncates toward zero.
  - lo_o = quotient, hi_o = remainder.
  - DIV: quotient negated iff sign(a) XOR sign(b); remainder takes the sign of a.
  - DIV with a = -2^(Width-1), b = -1: lo_o = 2^(Width-1) (the wrapped bit pattern), hi_o = 0; no trap.
  - Divide by zero (DIV or DIVU, b=0): hi_o = a (as latched), lo_o = all ones. Latency is unchanged.
- Magnitude of -2^(Width-1) is 2^(Width-1), held in Width bits unsigned; no overflow in the datapath.

Test Plan:
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi_o=FFFFFFFE, lo_o=00000001; done_o pulses exactly once, in the cycle after edge E+33; busy_o high for 33 cycles.
- MULT a=FFFFFFFD (-3), b=00000005 -> hi_o=FFFFFFFF, lo_o=FFFFFFF1. Then MULT a=80000000, b=80000000 -> hi_o=40000000, lo_o=00000000.
- DIV a=FFFFFFF9 (-7), b=2 -> lo_o=FFFFFFFD, hi_o=FFFFFFFF. Then DIV a=80000000, b=FFFFFFFF -> lo_o=80000000, hi_o=0.
- DIVU a=7, b=0 -> hi_o=00000007, lo_o=FFFFFFFF with normal latency. Then DIV a=FFFFFFF9, b=0 -> hi_o=FFFFFFF9, lo_o=FFFFFFFF.
- start_i held high with changing operands during CALC -> first operation's result is unaffected. Start held in the DONE cycle -> next operation is accepted immediately; hi_o/lo_o keep the old result until the new done_o.
- rst_ni pulsed low mid-CALC, asynchronously between edges -> busy_o, hi_o, lo_o drop to 0 immediately; no done_o follows; a fresh MULTU 3*4 afterwards gives lo_o=0000000C, hi_o=0.
